// File: rtl/spi_prot_trig.sv
// Passive SPI frame monitor: pulses SPItrig_o when a received MOSI word matches under mask.
// Optional SPI_TRIG_CAPTURE_EN adds rx_word_o and frame_err_o for host readback.
module spi_prot_trig #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        edg_i,
    input  logic        len8_i,
    input  logic [15:0] match_i,
    input  logic [15:0] mask_i,
    input  logic        SS_n_i,
    input  logic        SCLK_i,
    input  logic        MOSI_i,
    output logic        SPItrig_o
`ifdef SPI_TRIG_CAPTURE_EN
    ,
    output logic [15:0] rx_word_o,
    output logic        frame_err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RX,
        CHECK
    } state_t;

    // Bus lines packed as {SS_n, SCLK, MOSI}; flops reset high so an idle bus reads high.
    logic [2:0] syncStage_q [SYNC_STAGES];
    logic [2:0] edgeStage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncStage_q[i] <= 3'b111;
            end
            edgeStage_q <= 3'b111;
        end else begin
            syncStage_q[0] <= {SS_n_i, SCLK_i, MOSI_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncStage_q[i] <= syncStage_q[i-1];
            end
            edgeStage_q <= syncStage_q[SYNC_STAGES-1];
        end
    end

    logic ssS2, ssS3, sclkS2, sclkS3;
    logic ssFall, ssRise, sclkEdge, mosiBit;

    assign ssS2     = syncStage_q[SYNC_STAGES-1][2];
    assign ssS3     = edgeStage_q[2];
    assign sclkS2   = syncStage_q[SYNC_STAGES-1][1];
    assign sclkS3   = edgeStage_q[1];
    assign ssFall   = ~ssS2 & ssS3;
    assign ssRise   = ssS2 & ~ssS3;
    assign sclkEdge = edg_i ? (sclkS2 & ~sclkS3) : (~sclkS2 & sclkS3);
    assign mosiBit  = edgeStage_q[0];

    state_t      state_q, state_d;
    logic [15:0] shft_q, shft_d;
    logic [4:0]  bitCnt_q, bitCnt_d;
    logic        trig_q, trig_d;

    logic [15:0] compareMask;
    logic [15:0] diffBits;
    logic        cntOk;
    logic        hit;

    // A frame hits only with the exact bit count and no cared-about bit differing.
    assign compareMask = len8_i ? 16'h00FF : 16'hFFFF;
    assign diffBits    = (shft_q ^ match_i) & ~mask_i & compareMask;
    assign cntOk       = (bitCnt_q == (len8_i ? 5'd8 : 5'd16));
    assign hit         = cntOk && (diffBits == 16'h0000);

`ifdef SPI_TRIG_CAPTURE_EN
    logic [15:0] rxWord_q, rxWord_d;
    logic        frameErr_q, frameErr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shft_q   <= 16'h0000;
            bitCnt_q <= 5'd0;
            trig_q   <= 1'b0;
`ifdef SPI_TRIG_CAPTURE_EN
            rxWord_q   <= 16'h0000;
            frameErr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shft_q   <= shft_d;
            bitCnt_q <= bitCnt_d;
            trig_q   <= trig_d;
`ifdef SPI_TRIG_CAPTURE_EN
            rxWord_q   <= rxWord_d;
            frameErr_q <= frameErr_d;
`endif
        end
    end

    // A shift and an SS_n rise in the same cycle both apply; CHECK then sees the updated word.
    always_comb begin
        state_d  = state_q;
        shft_d   = shft_q;
        bitCnt_d = bitCnt_q;
        trig_d   = 1'b0;
`ifdef SPI_TRIG_CAPTURE_EN
        rxWord_d   = rxWord_q;
        frameErr_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                shft_d   = 16'h0000;
                bitCnt_d = 5'd0;
                if (ssFall && en_i) begin
                    state_d = RX;
                end
            end
            RX: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else begin
                    if (sclkEdge) begin
                        shft_d = {shft_q[14:0], mosiBit};
                        if (bitCnt_q != 5'd17) begin
                            bitCnt_d = bitCnt_q + 5'd1;
                        end
                    end
                    if (ssRise) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                trig_d  = hit;
                state_d = IDLE;
`ifdef SPI_TRIG_CAPTURE_EN
                rxWord_d   = shft_q;
                frameErr_d = ~cntOk;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SPItrig_o = trig_q;
`ifdef SPI_TRIG_CAPTURE_EN
    assign rx_word_o   = rxWord_q;
    assign frame_err_o = frameErr_q;
`endif

endmodule

// File: tb/tb_spi_prot_trig.sv
// Randomized scoreboard bench for spi_prot_trig; expected frame outcomes come from a wire-level
// reference model and are checked by an independent monitor at the expected output cycle.
module tb_spi_prot_trig;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic        edgSel;
    logic        len8;
    logic [15:0] matchW;
    logic [15:0] maskW;
    logic        ssN;
    logic        sclk;
    logic        mosi;
    logic        spiTrig;
`ifdef SPI_TRIG_CAPTURE_EN
    logic [15:0] rxWord;
    logic        frameErr;
`endif

    int totalCnt = 0;
    int badCnt   = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        bit          hit;
        bit          err;
        bit          checkWord;
        logic [15:0] word;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    spi_prot_trig #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .edg_i      (edgSel),
        .len8_i     (len8),
        .match_i    (matchW),
        .mask_i     (maskW),
        .SS_n_i     (ssN),
        .SCLK_i     (sclk),
        .MOSI_i     (mosi),
        .SPItrig_o  (spiTrig)
`ifdef SPI_TRIG_CAPTURE_EN
        ,
        .rx_word_o  (rxWord),
        .frame_err_o(frameErr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // What the receiver sees on the wire: sampling on the launch edge picks up the previous bit.
    function automatic void refModel(input logic [16:0] data, input int n, input bit cpol,
                                     input bit edgS, input bit l8, input logic [15:0] m,
                                     input logic [15:0] mk, output bit hit, output bit err,
                                     output logic [15:0] word);
        bit          shifted;
        logic        b;
        logic [15:0] care;
        int          need;
        shifted = (edgS != cpol);
        need    = l8 ? 8 : 16;
        word    = 16'h0000;
        for (int i = 0; i < n; i++) begin
            if (shifted) b = (i == 0) ? 1'b0 : data[n-i];
            else         b = data[n-1-i];
            word = {word[14:0], b};
        end
        care = ~mk & (l8 ? 16'h00FF : 16'hFFFF);
        err  = ((n > 17 ? 17 : n) != need);
        hit  = !err && ((word & care) == (m & care));
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        totalCnt++;
        if (act !== want) begin
            badCnt++;
            $display("[TB] FAIL %s: got %h want %h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // Monitor: compares outputs only at scheduled cycles, flags any pulse nobody asked for.
    always @(negedge clk) begin
        if (rst) begin
            check("reset SPItrig", {15'd0, spiTrig}, 16'h0000);
`ifdef SPI_TRIG_CAPTURE_EN
            check("reset rx_word", rxWord, 16'h0000);
            check("reset frame_err", {15'd0, frameErr}, 16'h0000);
`endif
        end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
            monE = expQ.pop_front();
            check("frame SPItrig", {15'd0, spiTrig}, {15'd0, monE.hit});
`ifdef SPI_TRIG_CAPTURE_EN
            check("frame frame_err", {15'd0, frameErr}, {15'd0, monE.err});
            if (monE.checkWord) check("frame rx_word", rxWord, monE.word);
`endif
        end else if (spiTrig) begin
            check("stray SPItrig", {15'd0, spiTrig}, 16'h0000);
        end
    end

    task automatic applyStimulus(input logic [16:0] data, input int n, input bit cpol,
                                 input int abortAt, input bit useRst);
        bit          hit, err, aborted;
        logic [15:0] word;
        exp_t        e;
        aborted = 1'b0;
        @(negedge clk);
        sclk = cpol;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        ssN = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == abortAt) begin
                if (useRst) begin
                    rst = 1'b1;
                    repeat (2) @(negedge clk);
                    ssN  = 1'b1;
                    sclk = cpol;
                    mosi = 1'b0;
                    repeat (3) @(negedge clk);
                    rst = 1'b0;
                    repeat (4) @(negedge clk);
                    return;
                end
                en      = 1'b0;
                aborted = 1'b1;
            end
            sclk = ~cpol;
            mosi = data[n-1-i];
            repeat (HALF) @(negedge clk);
            sclk = cpol;
            repeat (HALF) @(negedge clk);
        end
        ssN = 1'b1;
        refModel(data, n, cpol, edgSel, len8, matchW, maskW, hit, err, word);
        e.due       = cyc + 4;
        e.hit       = aborted ? 1'b0 : hit;
        e.err       = aborted ? 1'b0 : err;
        e.checkWord = !aborted;
        e.word      = word;
        expQ.push_back(e);
        en   = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic busNoise();
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            repeat (3) @(negedge clk);
        end
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic setCfg(input bit e, input bit l8, input logic [15:0] m, input logic [15:0] mk);
        edgSel = e;
        len8   = l8;
        matchW = m;
        maskW  = mk;
    endtask

    initial begin
        bit          h, er, cp;
        int          n;
        logic [15:0] w;
        logic [16:0] data;
        int          lens[6] = '{7, 8, 9, 15, 16, 17};

        en = 1'b1; edgSel = 1'b0; len8 = 1'b0; matchW = 16'h0; maskW = 16'h0;
        ssN = 1'b1; sclk = 1'b0; mosi = 1'b0;
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        setCfg(1'b0, 1'b0, 16'hABCD, 16'h0000);
        applyStimulus(17'h0ABCD, 16, 1'b0, -1, 1'b0);
        setCfg(1'b0, 1'b0, 16'h00CD, 16'h0000);
        applyStimulus(17'h0ABCD, 16, 1'b0, -1, 1'b0);
        repeat (4000) @(negedge clk);
        setCfg(1'b0, 1'b0, 16'h00CD, 16'hFF00);
        applyStimulus(17'h0ABCD, 16, 1'b0, -1, 1'b0);

        setCfg(1'b0, 1'b1, 16'h00CD, 16'h0000);
        applyStimulus(17'h000CD, 8, 1'b0, -1, 1'b0);
        applyStimulus(17'h0ABCD, 16, 1'b0, -1, 1'b0);

        setCfg(1'b1, 1'b0, 16'h1234, 16'h0000);
        applyStimulus(17'h01234, 16, 1'b1, -1, 1'b0);
        setCfg(1'b0, 1'b0, 16'h1234, 16'h0000);
        applyStimulus(17'h01234, 16, 1'b1, -1, 1'b0);

        setCfg(1'b0, 1'b0, 16'hABCD, 16'h0000);
        applyStimulus(17'h0ABCD, 16, 1'b0, 7, 1'b1);
        applyStimulus(17'h0ABCD, 16, 1'b0, 5, 1'b0);
        applyStimulus(17'h0ABCD, 16, 1'b0, -1, 1'b0);

        applyStimulus(17'h1ABCD, 17, 1'b0, -1, 1'b0);
        busNoise();
        applyStimulus(17'h0ABCD, 16, 1'b0, -1, 1'b0);

        setCfg(1'b1, 1'b0, 16'h5A5A, 16'hFFFF);
        applyStimulus(17'h00F0F, 16, 1'b1, -1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            n    = lens[$urandom_range(0, 5)];
            cp   = 1'($urandom);
            data = 17'($urandom);
            case ($urandom_range(0, 3))
                0:       maskW = 16'h0000;
                1:       maskW = 16'hFFFF;
                default: maskW = 16'($urandom & $urandom);
            endcase
            edgSel = 1'($urandom);
            len8   = 1'($urandom);
            refModel(data, n, cp, edgSel, len8, 16'h0000, maskW, h, er, w);
            matchW = ($urandom_range(0, 1) == 1) ? (w ^ (16'($urandom) & maskW)) : 16'($urandom);
            applyStimulus(data, n, cp, -1, 1'b0);
        end

        for (int t = 0; t < 100 && expQ.size() != 0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: bench did not complete, pending=%0d", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
